// File: rtl/fft_pkg.sv
// Constants and types shared by the FFT core, the output sorter and the result unpacker.
package fft_pkg;

    localparam int DW    = 17;
    localparam int N     = 32;
    localparam int LOG2N = 5;

    typedef logic signed [DW-1:0] sample_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_t;

endpackage

// File: rtl/result_bank.sv
// One frame of storage: N real and N imaginary samples, single write port,
// combinational read of a real/imag pair at the same address.
module result_bank
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [LOG2N-1:0] i_wr_addr,
    input  logic             i_wr_sel_imag,
    input  sample_t          i_wr_data,
    input  logic [LOG2N-1:0] i_rd_addr,
    output sample_t          o_rd_re,
    output sample_t          o_rd_im
);

    sample_t r_re [N];
    sample_t r_im [N];

    // NOTE: storage has no reset; every entry is rewritten before its bank is marked full.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            if (i_wr_sel_imag) begin
                r_im[i_wr_addr] <= i_wr_data;
            end else begin
                r_re[i_wr_addr] <= i_wr_data;
            end
        end
    end

    assign o_rd_re = r_re[i_rd_addr];
    assign o_rd_im = r_im[i_rd_addr];

endmodule

// File: rtl/result_unpacker.sv
// Collects 32 real then 32 imaginary words per frame into one of two banks and
// replays them as complex samples over a valid/ready handshake.
module result_unpacker
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             seq,
    input  sample_t          answer,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOG2N-1:0] out_idx,
    output sample_t          out_r,
    output sample_t          out_i,
    output logic             frame_done,
    output logic             overrun
);

    localparam logic [LOG2N:0]   LAST_WORD = (LOG2N+1)'(2*N-1);
    localparam logic [LOG2N-1:0] LAST_IDX  = LOG2N'(N-1);

    logic [LOG2N:0]   r_wr_cnt;
    logic             r_wr_bank;
    logic             r_drop;
    logic             r_overrun;
    logic [1:0]       r_full;
    rd_state_t        r_state;
    rd_state_t        w_state_nxt;
    logic             r_rd_bank;
    logic [LOG2N-1:0] r_rd_idx;

    logic             w_handshake;
    logic             w_release;
    logic             w_first;
    logic             w_last;
    logic             w_target_full;
    logic             w_drop;
    logic             w_wr_en;
    logic [1:0]       w_set_full;
    logic [1:0]       w_clr_full;
    sample_t          w_re [2];
    sample_t          w_im [2];

    assign w_handshake = out_valid && out_ready;
    assign w_release   = w_handshake && (r_rd_idx == LAST_IDX);
    assign w_first     = seq && (r_wr_cnt == '0);
    assign w_last      = seq && (r_wr_cnt == LAST_WORD);

    // A bank being released this very cycle is free for a frame starting now.
    assign w_target_full = r_full[r_wr_bank] && !(w_release && (r_rd_bank == r_wr_bank));
    assign w_drop        = (r_wr_cnt == '0) ? w_target_full : r_drop;
    assign w_wr_en       = seq && !w_drop;

    assign w_set_full = (w_last && !w_drop) ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr_full = w_release ? (2'b01 << r_rd_bank) : 2'b00;

    // A dropped frame leaves the write pointer alone so banks stay in arrival order.
    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
            r_drop    <= 1'b0;
            r_overrun <= 1'b0;
            r_full    <= 2'b00;
            r_rd_bank <= 1'b0;
            r_rd_idx  <= '0;
        end else begin
            if (seq) begin
                r_wr_cnt <= w_last ? '0 : r_wr_cnt + 1'b1;
                if (r_wr_cnt == '0) begin
                    r_drop <= w_target_full;
                end
                if (w_last && !w_drop) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_first && w_target_full) begin
                r_overrun <= 1'b1;
            end
            r_full <= (r_full & ~w_clr_full) | w_set_full;
            if (w_handshake) begin
                r_rd_idx <= w_release ? '0 : r_rd_idx + 1'b1;
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RD_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_state_nxt = RD_SEND;
                end
            end
            RD_SEND: begin
                if (w_release) begin
                    w_state_nxt = r_full[~r_rd_bank] ? RD_SEND : RD_IDLE;
                end
            end
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    result_bank u_bank0 (
        .clk           (clk),
        .i_wr_en       (w_wr_en && (r_wr_bank == 1'b0)),
        .i_wr_addr     (r_wr_cnt[LOG2N-1:0]),
        .i_wr_sel_imag (r_wr_cnt[LOG2N]),
        .i_wr_data     (answer),
        .i_rd_addr     (r_rd_idx),
        .o_rd_re       (w_re[0]),
        .o_rd_im       (w_im[0])
    );

    result_bank u_bank1 (
        .clk           (clk),
        .i_wr_en       (w_wr_en && (r_wr_bank == 1'b1)),
        .i_wr_addr     (r_wr_cnt[LOG2N-1:0]),
        .i_wr_sel_imag (r_wr_cnt[LOG2N]),
        .i_wr_data     (answer),
        .i_rd_addr     (r_rd_idx),
        .o_rd_re       (w_re[1]),
        .o_rd_im       (w_im[1])
    );

    assign out_valid  = (r_state == RD_SEND);
    assign out_idx    = r_rd_idx;
    assign out_r      = out_valid ? w_re[r_rd_bank] : '0;
    assign out_i      = out_valid ? w_im[r_rd_bank] : '0;
    assign frame_done = w_release;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_result_unpacker.sv
// Scoreboard bench for result_unpacker: expected samples are queued as frames are
// sent and compared on every output handshake.
module tb_result_unpacker;
    import fft_pkg::*;

    logic             clk;
    logic             rst;
    logic             seq;
    sample_t          answer;
    logic             out_valid;
    logic             out_ready;
    logic [LOG2N-1:0] out_idx;
    sample_t          out_r;
    sample_t          out_i;
    logic             frame_done;
    logic             overrun;

    result_unpacker dut (
        .clk        (clk),
        .rst        (rst),
        .seq        (seq),
        .answer     (answer),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_r      (out_r),
        .out_i      (out_i),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    typedef struct {
        logic [LOG2N-1:0] idx;
        sample_t          re;
        sample_t          im;
    } exp_t;

    exp_t    sb[$];
    int      checks;
    int      errors;
    int      hs_count;
    int      cyc;
    int      ready_mode;
    sample_t re_v [N];
    sample_t im_v [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and drive out_ready: 0 = always ready, 1 = 1,0,0 pattern, 2 = never.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic send_frame(input bit accept, input int gap_pct, input int nwords);
        if (accept) begin
            for (int k = 0; k < N; k++) begin
                sb.push_back('{idx: LOG2N'(k), re: re_v[k], im: im_v[k]});
            end
        end
        for (int w = 0; w < nwords; w++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                seq = 1'b0;
                answer = sample_t'(17'h0AAAA);
                tick();
            end
            seq = 1'b1;
            answer = (w < N) ? re_v[w] : im_v[w-N];
            tick();
        end
        seq = 1'b0;
        answer = '0;
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((sb.size() > 0 || out_valid) && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d out_valid=%b, required pending=0 out_valid=0",
                     sb.size(), out_valid);
        end
    endtask

    // Output monitor: scoreboard compare on handshakes, hold check during stalls.
    logic             p_stall;
    logic [LOG2N-1:0] p_idx;
    sample_t          p_r;
    sample_t          p_i;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_idx !== p_idx || out_r !== p_r || out_i !== p_i) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b idx=%0d r=%0d i=%0d, required v=1 idx=%0d r=%0d i=%0d",
                             out_valid, out_idx, out_r, out_i, p_idx, p_r, p_i);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                hs_count++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: idx=%0d r=%0d i=%0d with empty scoreboard",
                             out_idx, out_r, out_i);
                end else begin
                    e = sb.pop_front();
                    if (out_idx !== e.idx || out_r !== e.re || out_i !== e.im ||
                        frame_done !== (e.idx == LOG2N'(N-1))) begin
                        errors++;
                        $display("FAIL sample: got idx=%0d r=%0d i=%0d fd=%b, required idx=%0d r=%0d i=%0d fd=%b",
                                 out_idx, out_r, out_i, frame_done, e.idx, e.re, e.im,
                                 (e.idx == LOG2N'(N-1)));
                    end
                end
            end else begin
                checks++;
                if (frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_done_idle: got %b, required 0", frame_done);
                end
                if (out_valid !== 1'b1) begin
                    checks++;
                    if (out_r !== '0 || out_i !== '0) begin
                        errors++;
                        $display("FAIL zero_when_invalid: got r=%0d i=%0d, required 0 0", out_r, out_i);
                    end
                end
            end
            p_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
            p_idx   = out_idx;
            p_r     = out_r;
            p_i     = out_i;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        seq = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_idx !== '0 || out_r !== '0 || out_i !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b idx=%0d r=%0d i=%0d, required all 0",
                     out_valid, out_idx, out_r, out_i);
        end
        checks++;
        if (frame_done !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got fd=%b ovr=%b, required 0 0", frame_done, overrun);
        end
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_single_frame();
        int n;
        ready_mode = 0;
        hs_count = 0;
        for (int k = 0; k < N; k++) begin
            re_v[k] = sample_t'(k);
            im_v[k] = sample_t'(1000 + k);
        end
        send_frame(1'b1, 0, 2*N);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got out_valid=%b right after w=63, required 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== '0) begin
            errors++;
            $display("FAIL latency: got v=%b idx=%0d one cycle after w=63, required v=1 idx=0",
                     out_valid, out_idx);
        end
        n = 0;
        while (out_valid === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != N) begin
            errors++;
            $display("FAIL throughput: got %0d valid cycles, required %0d", n, N);
        end
        wait_drain(200);
        checks++;
        if (hs_count != N) begin
            errors++;
            $display("FAIL single_count: got %0d handshakes, required %0d", hs_count, N);
        end
    endtask

    task automatic test_backpressure();
        ready_mode = 1;
        hs_count = 0;
        for (int k = 0; k < N; k++) begin
            re_v[k] = sample_t'(k);
            im_v[k] = sample_t'(1000 + k);
        end
        send_frame(1'b1, 0, 2*N);
        wait_drain(400);
        checks++;
        if (hs_count != N) begin
            errors++;
            $display("FAIL backpressure_count: got %0d handshakes, required %0d", hs_count, N);
        end
    endtask

    task automatic test_back_to_back();
        ready_mode = 0;
        hs_count = 0;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) begin
                re_v[k] = sample_t'(100*f + k);
                im_v[k] = sample_t'(-(100*f + k) - 1);
            end
            send_frame(1'b1, 0, 2*N);
        end
        wait_drain(400);
        checks++;
        if (hs_count != 3*N || overrun !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: got %0d handshakes ovr=%b, required %0d ovr=0",
                     hs_count, overrun, 3*N);
        end
    endtask

    task automatic test_overrun();
        ready_mode = 2;
        hs_count = 0;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) begin
                re_v[k] = sample_t'(100*f + k);
                im_v[k] = sample_t'(2000 + 100*f + k);
            end
            send_frame(f < 2, 0, 2*N);
        end
        tick();
        checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b1 || out_idx !== '0) begin
            errors++;
            $display("FAIL overrun_set: got ovr=%b v=%b idx=%0d, required ovr=1 v=1 idx=0",
                     overrun, out_valid, out_idx);
        end
        ready_mode = 0;
        wait_drain(400);
        checks++;
        if (hs_count != 2*N || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_drain: got %0d handshakes ovr=%b, required %0d ovr=1",
                     hs_count, overrun, 2*N);
        end
    endtask

    task automatic test_gaps_and_reset();
        ready_mode = 0;
        for (int k = 0; k < N; k++) begin
            re_v[k] = sample_t'(3*k - 40);
            im_v[k] = sample_t'(500 - 7*k);
        end
        send_frame(1'b1, 30, 2*N);
        wait_drain(400);
        // Buffer one frame, then reset partway through the next one.
        ready_mode = 2;
        send_frame(1'b0, 0, 2*N);
        send_frame(1'b0, 20, 40);
        seq = 1'b1;
        answer = sample_t'(17'h15555);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seq = 1'b0;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0 || out_idx !== '0 || out_r !== '0 || out_i !== '0 ||
            frame_done !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: got v=%b idx=%0d r=%0d i=%0d fd=%b ovr=%b, required all 0",
                     out_valid, out_idx, out_r, out_i, frame_done, overrun);
        end
        ready_mode = 0;
        hs_count = 0;
        for (int k = 0; k < N; k++) begin
            re_v[k] = sample_t'(-7*k);
            im_v[k] = sample_t'(13*k - 200);
        end
        send_frame(1'b1, 0, 2*N);
        wait_drain(200);
        checks++;
        if (hs_count != N) begin
            errors++;
            $display("FAIL post_reset_count: got %0d handshakes, required %0d", hs_count, N);
        end
    endtask

    task automatic test_negative();
        ready_mode = 2;
        for (int k = 0; k < N; k++) begin
            re_v[k] = (k % 2 == 0) ? sample_t'(-65536) : sample_t'(65535);
            im_v[k] = (k % 2 == 0) ? sample_t'(65535) : sample_t'(-65536);
        end
        re_v[5] = sample_t'(-1);
        im_v[6] = sample_t'(-1);
        send_frame(1'b1, 0, 2*N);
        tick();
        checks++;
        if (!(out_r < 0) || out_r !== sample_t'(-65536) || out_i !== sample_t'(65535)) begin
            errors++;
            $display("FAIL extremes: got r=%0d i=%0d, required r=-65536 i=65535", out_r, out_i);
        end
        ready_mode = 0;
        wait_drain(200);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hs_count = 0;
        cyc = 0;
        ready_mode = 0;
        rst = 1'b1;
        seq = 1'b0;
        answer = '0;
        out_ready = 1'b0;

        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset();
        test_gaps_and_reset();
        test_negative();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
